// File: rtl/tb_clock_checker_pkg.sv
// Shared types and defaults for the monitored-clock checker.
// FSM encoding and default counter/limit sizing live here.
package tb_clock_checker_pkg;

    localparam int DEF_CNT_W       = 16;
    localparam int DEF_STUCK_LIMIT = 16'hFFFF;
    localparam int MIN_SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_RISE,
        ST_MEAS_HIGH,
        ST_MEAS_LOW
    } state_e;

endpackage

// File: rtl/tb_sync_edge.sv
// Brings the asynchronous monitored clock into the CLK domain
// and turns its transitions into single-cycle rise/fall pulses.
module tb_sync_edge
    import tb_clock_checker_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic mon_clk,
    output logic rise,
    output logic fall
);

    // Never fewer than two flops, whatever the caller asks for.
    localparam int N = (SYNC_STAGES < MIN_SYNC_STAGES) ?
                       MIN_SYNC_STAGES : SYNC_STAGES;

    logic [N-1:0] sync_q;
    logic         edge_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            edge_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[N-2:0], mon_clk};
            edge_q <= sync_q[N-1];
        end
    end

    assign rise = sync_q[N-1] & ~edge_q;
    assign fall = ~sync_q[N-1] & edge_q;

endmodule

// File: rtl/tb_clock_checker.sv
// Measures period and high time of a monitored clock in CLK cycles,
// publishes them over a valid/ready handshake and flags violations.
module tb_clock_checker
    import tb_clock_checker_pkg::*;
#(
    parameter int          CNT_W       = DEF_CNT_W,
    parameter int          SYNC_STAGES = 2,
    parameter int unsigned STUCK_LIMIT = DEF_STUCK_LIMIT
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [1:0]       tb_status,
    input  logic             MON_CLK,
    input  logic [CNT_W-1:0] period_min,
    input  logic [CNT_W-1:0] period_max,
    input  logic [CNT_W-1:0] high_min,
    input  logic [CNT_W-1:0] high_max,
    output logic             meas_valid,
    input  logic             meas_ready,
    output logic [CNT_W-1:0] meas_period,
    output logic [CNT_W-1:0] meas_high,
    output logic             err_period,
    output logic             err_high,
    output logic             err_stuck,
    output logic             err_overrun
);

    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
    localparam logic [CNT_W-1:0] STUCK_LIM = CNT_W'(STUCK_LIMIT);

    function automatic logic [CNT_W-1:0] sat_inc(
        input logic [CNT_W-1:0] v
    );
        return (&v) ? v : v + ONE;
    endfunction

    function automatic logic [CNT_W-1:0] sat_add(
        input logic [CNT_W-1:0] a,
        input logic [CNT_W-1:0] b
    );
        logic [CNT_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[CNT_W] ? '1 : s[CNT_W-1:0];
    endfunction

    state_e           state_q, state_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic [CNT_W-1:0] low_q, low_d;
    logic [CNT_W-1:0] stuck_q, stuck_d, stuck_inc;
    logic [CNT_W-1:0] pub_period;
    logic             en, en_q, en_rise;
    logic             rise, fall;
    logic             publish, stuck_hit;
    logic             period_bad, high_bad;
    logic             xfer, load, drop;
    logic             unused_status;

    assign unused_status = tb_status[1];
    assign en            = tb_status[0];
    assign en_rise       = en & ~en_q;

    tb_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clk     (CLK),
        .rst     (RST),
        .mon_clk (MON_CLK),
        .rise    (rise),
        .fall    (fall)
    );

    always_comb begin
        state_d = state_q;
        high_d  = high_q;
        low_d   = low_q;
        publish = 1'b0;
        if (!en) begin
            state_d = ST_IDLE;
            high_d  = '0;
            low_d   = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    state_d = ST_WAIT_RISE;
                    high_d  = '0;
                    low_d   = '0;
                end
                ST_WAIT_RISE: begin
                    if (rise) begin
                        state_d = ST_MEAS_HIGH;
                        high_d  = ONE;
                        low_d   = '0;
                    end
                end
                ST_MEAS_HIGH: begin
                    if (fall) begin
                        state_d = ST_MEAS_LOW;
                        low_d   = ONE;
                    end else begin
                        high_d = sat_inc(high_q);
                    end
                end
                ST_MEAS_LOW: begin
                    if (rise) begin
                        publish = 1'b1;
                        state_d = ST_MEAS_HIGH;
                        high_d  = ONE;
                        low_d   = '0;
                    end else begin
                        low_d = sat_inc(low_q);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Cycles since the last edge; zero whenever idle or disabled.
    assign stuck_inc = sat_inc(stuck_q);

    always_comb begin
        stuck_d   = '0;
        stuck_hit = 1'b0;
        if (en && state_q != ST_IDLE && !rise && !fall) begin
            stuck_d   = stuck_inc;
            stuck_hit = (stuck_inc >= STUCK_LIM);
        end
    end

    assign pub_period = sat_add(high_q, low_q);
    assign period_bad = (pub_period < period_min) ||
                        (pub_period > period_max);
    assign high_bad   = (high_q < high_min) || (high_q > high_max);

    assign xfer = meas_valid & meas_ready;
    assign load = publish & (~meas_valid | meas_ready);
    assign drop = publish & meas_valid & ~meas_ready;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            high_q  <= '0;
            low_q   <= '0;
            stuck_q <= '0;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            high_q  <= high_d;
            low_q   <= low_d;
            stuck_q <= stuck_d;
            en_q    <= en;
        end
    end

    // Pending data is kept across disable until the consumer takes it.
    always_ff @(posedge CLK) begin
        if (RST) begin
            meas_valid  <= 1'b0;
            meas_period <= '0;
            meas_high   <= '0;
        end else if (load) begin
            meas_valid  <= 1'b1;
            meas_period <= pub_period;
            meas_high   <= high_q;
        end else if (xfer) begin
            meas_valid  <= 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST || en_rise) begin
            err_period  <= 1'b0;
            err_high    <= 1'b0;
            err_stuck   <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            if (publish && period_bad) err_period <= 1'b1;
            if (publish && high_bad)   err_high   <= 1'b1;
            if (stuck_hit)             err_stuck  <= 1'b1;
            if (drop)                  err_overrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_tb_clock_checker.sv
// Directed bench for tb_clock_checker: period/high measurement,
// handshake, sticky errors, stuck detection, disable and reset.
module tb_tb_clock_checker;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  tb_status;
    logic        mon_clk = 1'b0;
    logic [15:0] period_min, period_max, high_min, high_max;
    logic        meas_valid, meas_ready;
    logic [15:0] meas_period, meas_high;
    logic        err_period, err_high, err_stuck, err_overrun;

    int errors = 0;
    int checks = 0;
    int mon_hi = 10;
    int mon_lo = 10;
    bit mon_run = 1'b0;
    int n;
    bit any_v;

    always #5 clk = ~clk;

    // Monitored clock, toggling on CLK falling edges.
    always begin
        if (mon_run) begin
            mon_clk = 1'b1;
            repeat (mon_hi) @(negedge clk);
            mon_clk = 1'b0;
            repeat (mon_lo) @(negedge clk);
        end else begin
            mon_clk = 1'b0;
            @(negedge clk);
        end
    end

    tb_clock_checker #(
        .CNT_W       (16),
        .SYNC_STAGES (2),
        .STUCK_LIMIT (100)
    ) dut (
        .CLK         (clk),
        .RST         (rst),
        .tb_status   (tb_status),
        .MON_CLK     (mon_clk),
        .period_min  (period_min),
        .period_max  (period_max),
        .high_min    (high_min),
        .high_max    (high_max),
        .meas_valid  (meas_valid),
        .meas_ready  (meas_ready),
        .meas_period (meas_period),
        .meas_high   (meas_high),
        .err_period  (err_period),
        .err_high    (err_high),
        .err_stuck   (err_stuck),
        .err_overrun (err_overrun)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(input int budget, output int cnt);
        cnt = 0;
        do begin
            step();
            cnt++;
        end while (!meas_valid && cnt < budget);
        chk("valid_seen", 32'(meas_valid), 1);
    endtask

    initial begin
        rst        = 1'b1;
        tb_status  = 2'b00;
        meas_ready = 1'b1;
        period_min = 16'd18;
        period_max = 16'd22;
        high_min   = 16'd8;
        high_max   = 16'd12;
        repeat (3) step();
        chk("rst_valid", 32'(meas_valid), 0);
        chk("rst_period", 32'(meas_period), 0);
        chk("rst_high", 32'(meas_high), 0);
        chk("rst_err_period", 32'(err_period), 0);
        chk("rst_err_high", 32'(err_high), 0);
        chk("rst_err_stuck", 32'(err_stuck), 0);
        chk("rst_err_overrun", 32'(err_overrun), 0);
        rst = 1'b0;

        // 10/10 clock within limits
        tb_status = 2'b01;
        mon_run   = 1'b1;
        wait_valid(100, n);
        chk("p20_period0", 32'(meas_period), 20);
        chk("p20_high0", 32'(meas_high), 10);
        for (int k = 0; k < 3; k++) begin
            wait_valid(40, n);
            chk("p20_interval", 32'(n), 20);
            chk("p20_period", 32'(meas_period), 20);
            chk("p20_high", 32'(meas_high), 10);
        end
        chk("p20_err_period", 32'(err_period), 0);
        chk("p20_err_high", 32'(err_high), 0);
        chk("p20_err_overrun", 32'(err_overrun), 0);
        chk("p20_err_stuck", 32'(err_stuck), 0);

        // 5/15 clock violates high_min
        tb_status = 2'b00;
        mon_run   = 1'b0;
        repeat (30) step();
        mon_hi    = 5;
        mon_lo    = 15;
        tb_status = 2'b01;
        mon_run   = 1'b1;
        wait_valid(100, n);
        chk("h5_high", 32'(meas_high), 5);
        chk("h5_period", 32'(meas_period), 20);
        chk("h5_err_high", 32'(err_high), 1);
        chk("h5_err_period", 32'(err_period), 0);
        wait_valid(40, n);
        chk("h5_err_high_sticky", 32'(err_high), 1);
        tb_status = 2'b00;
        mon_run   = 1'b0;
        repeat (30) step();
        chk("h5_err_high_disabled", 32'(err_high), 1);
        mon_hi    = 10;
        mon_lo    = 10;
        tb_status = 2'b01;
        step();
        chk("h5_err_high_cleared", 32'(err_high), 0);

        // consumer stalls: first value held, later ones dropped
        tb_status  = 2'b00;
        step();
        meas_ready = 1'b0;
        tb_status  = 2'b01;
        mon_run    = 1'b1;
        wait_valid(100, n);
        chk("ovr_first_period", 32'(meas_period), 20);
        chk("ovr_first_high", 32'(meas_high), 10);
        mon_hi = 8;
        mon_lo = 12;
        repeat (50) step();
        chk("ovr_valid_held", 32'(meas_valid), 1);
        chk("ovr_period_held", 32'(meas_period), 20);
        chk("ovr_high_held", 32'(meas_high), 10);
        chk("ovr_err_overrun", 32'(err_overrun), 1);
        meas_ready = 1'b1;
        step();
        chk("ovr_valid_drop", 32'(meas_valid), 0);

        // disable mid-MEAS_LOW, then re-enable
        tb_status = 2'b00;
        mon_run   = 1'b0;
        repeat (30) step();
        mon_hi    = 10;
        mon_lo    = 10;
        high_max  = 16'd9;
        tb_status = 2'b01;
        mon_run   = 1'b1;
        wait_valid(100, n);
        chk("dis_high", 32'(meas_high), 10);
        chk("dis_err_high", 32'(err_high), 1);
        repeat (15) step();
        tb_status = 2'b00;
        repeat (3) step();
        high_max  = 16'd12;
        tb_status = 2'b01;
        step();
        chk("dis_err_cleared", 32'(err_high), 0);
        wait_valid(60, n);
        chk("dis_first_pub_delay", 32'(n), 21);
        chk("dis_period", 32'(meas_period), 20);
        chk("dis_high2", 32'(meas_high), 10);

        // reset during MEAS_HIGH with pending data and overrun
        meas_ready = 1'b0;
        repeat (23) step();
        chk("rstm_overrun_pre", 32'(err_overrun), 1);
        chk("rstm_valid_pre", 32'(meas_valid), 1);
        rst       = 1'b1;
        tb_status = 2'b00;
        step();
        chk("rstm_valid", 32'(meas_valid), 0);
        chk("rstm_period", 32'(meas_period), 0);
        chk("rstm_high", 32'(meas_high), 0);
        chk("rstm_overrun", 32'(err_overrun), 0);
        rst        = 1'b0;
        meas_ready = 1'b1;

        // MON_CLK stuck low
        mon_run = 1'b0;
        repeat (30) step();
        tb_status = 2'b01;
        step();
        any_v = 1'b0;
        repeat (99) begin
            step();
            if (meas_valid) any_v = 1'b1;
        end
        chk("stuck_before_limit", 32'(err_stuck), 0);
        step();
        chk("stuck_at_limit", 32'(err_stuck), 1);
        chk("stuck_no_valid", 32'(any_v), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tb_clock_checker.md
TB_CLOCK_CHECKER -- requirements
Module: tb_clock_checker

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of all duration counters and limits.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, number of synchronizer flops on MON_CLK (minimum 2).
REQ-003 SHALL have parameter STUCK_LIMIT, default 16'hFFFF, cycles without a MON_CLK edge before err_stuck is raised.
REQ-004 SHALL have port CLK  in  1  sampling clock, the single clock; all logic on its rising edge.
REQ-005 SHALL have port RST  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port tb_status  in  2  bit0 = measurement enable; bit1 unused.
REQ-007 SHALL have port MON_CLK  in  1  monitored clock, asynchronous to CLK (output of the upstream clock generator).
REQ-008 SHALL have ports period_min, period_max, high_min, high_max  in  CNT_W  inclusive limits in CLK cycles, static while enabled.
REQ-009 SHALL have port meas_valid  out  1  measurement available.
REQ-010 SHALL have port meas_ready  in  1  consumer accepts measurement.
REQ-011 SHALL have ports meas_period, meas_high  out  CNT_W  last published period and high time.
REQ-012 SHALL have ports err_period, err_high, err_stuck, err_overrun  out  1  sticky error flags.

Function
REQ-013 SHALL synchronize MON_CLK through SYNC_STAGES flops, then register it once more for edge detection; rise/fall pulse is 1 cycle, SYNC_STAGES+1 cycles after the MON_CLK transition.
REQ-014 SHALL implement FSM IDLE, WAIT_RISE, MEAS_HIGH, MEAS_LOW.
REQ-015 IDLE -> WAIT_RISE when tb_status[0]=1; any state -> IDLE the cycle after tb_status[0]=0, discarding the in-flight measurement.
REQ-016 WAIT_RISE discards the partial first cycle; on rise: high_cnt<=1, go to MEAS_HIGH.
REQ-017 MEAS_HIGH: high_cnt increments per cycle; on fall: low_cnt<=1, go to MEAS_LOW.
REQ-018 MEAS_LOW: low_cnt increments per cycle; on rise: publish period=high_cnt+low_cnt and high=high_cnt, set high_cnt<=1, low_cnt<=0, stay measuring (go to MEAS_HIGH).
REQ-019 Counters and the period sum SHALL saturate at all-ones, never wrap.
REQ-020 Publish: meas_valid=1 and meas_period/meas_high updated the cycle after the rise pulse; data held stable while meas_valid=1 and meas_ready=0.
REQ-021 Transfer occurs on a cycle with meas_valid=1 and meas_ready=1; meas_valid drops the next cycle unless a new publish occurs in that same cycle, in which case the new data loads and meas_valid stays 1.
REQ-022 Publish while meas_valid=1 and meas_ready=0: new data dropped, err_overrun set.
REQ-023 On publish: set err_period if period<period_min or period>period_max; set err_high if high<high_min or high>high_max; checks use the published values.
REQ-024 err_stuck SHALL be set when the cycle count since the last edge (or since entering WAIT_RISE) reaches STUCK_LIMIT in a non-IDLE state.
REQ-025 Sticky errors SHALL clear only on RST or on the cycle tb_status[0] goes 0->1.
REQ-026 Pending meas_valid SHALL survive tb_status[0] deassertion until transferred.

Reset
REQ-027 On RST=1: state IDLE, all counters 0, synchronizer and edge flops 0, meas_valid 0, meas_period 0, meas_high 0, all err_* 0; RST mid-measurement discards it with no publish.

Structure
REQ-028 Package tb_clock_checker_pkg SHALL hold the FSM state enum and the default CNT_W/STUCK_LIMIT constants.
REQ-029 Sub-module tb_sync_edge SHALL contain the synchronizer chain and the rise/fall pulse generator; the remainder (FSM, counters, handshake, checks) stays in tb_clock_checker.

Verification
REQ-030 MON_CLK 10 CLK high/10 low, limits 18..22 / 8..12, meas_ready=1 -> meas_period=20, meas_high=10 every 20 cycles, no errors.
REQ-031 MON_CLK 5 high/15 low, high_min=8 -> meas_high=5, err_high=1 and stays set until tb_status[0] re-rises.
REQ-032 meas_ready=0 for 50 cycles with a 20-cycle MON_CLK -> first value held, err_overrun=1, accepted value=first measurement.
REQ-033 MON_CLK held 0, STUCK_LIMIT=100, enable -> err_stuck=1 exactly 100 cycles after entering WAIT_RISE; meas_valid never asserts.
REQ-034 tb_status[0] dropped mid-MEAS_LOW, then re-raised -> no publish for the interrupted period, errors cleared, first publish after one full new period.
REQ-035 RST asserted during MEAS_HIGH -> all outputs 0 the next cycle, FSM IDLE.
